alu_req_arbiter: RTL and testbench



---
 rtl/alu_req_arbiter_if.sv | 46 ++++
 rtl/alu_req_arbiter.sv | 152 +++++++++++++++
 tb/tb_alu_req_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_req_arbiter_if.sv
// Bundle of requester, response and ALU-side signals for alu_req_arbiter.
// slave = arbiter view, master = command sources / response sink / ALU view.
interface alu_req_arbiter_if #(
    parameter int N       = 8,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 3
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*N-1:0] req_opa;
    logic [NUM_REQ*N-1:0] req_opb;
    logic [NUM_REQ-1:0]   req_cin;
    logic [NUM_REQ-1:0]   req_mode;
    logic [NUM_REQ*4-1:0] req_cmd;
    logic [NUM_REQ*2-1:0] req_inp_valid;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [2*N:0]         rsp_res;
    logic [6:0]           rsp_flags;

    logic [N-1:0]         alu_opa;
    logic [N-1:0]         alu_opb;
    logic                 alu_cin;
    logic                 alu_mode;
    logic                 alu_ce;
    logic [3:0]           alu_cmd;
    logic [1:0]           alu_inp_valid;
    logic [2*N:0]         alu_res;
    logic [6:0]           alu_flags;

    modport slave (
        input  req_valid, req_opa, req_opb, req_cin, req_mode, req_cmd, req_inp_valid,
        input  rsp_ready, alu_res, alu_flags,
        output req_ready, rsp_valid, rsp_id, rsp_res, rsp_flags,
        output alu_opa, alu_opb, alu_cin, alu_mode, alu_ce, alu_cmd, alu_inp_valid
    );

    modport master (
        output req_valid, req_opa, req_opb, req_cin, req_mode, req_cmd, req_inp_valid,
        output rsp_ready, alu_res, alu_flags,
        input  req_ready, rsp_valid, rsp_id, rsp_res, rsp_flags,
        input  alu_opa, alu_opb, alu_cin, alu_mode, alu_ce, alu_cmd, alu_inp_valid
    );
endinterface

// File: rtl/alu_req_arbiter.sv
// Shares one ALU between NUM_REQ requesters, one command in flight, tagged responses.
// Define ALU_FIXED_PRIO_EN for fixed lowest-index-wins arbitration instead of round-robin.
//
// state   | meaning
// IDLE    | arbitrate, grant one requester and latch its command
// ISSUE   | drive latched command to the ALU with inp_valid set
// WAIT    | ALU computing; 1 cycle, 2 for multiply
// CAPTURE | register ALU result/flags into the response port
// RESP    | hold response until rsp_ready
module alu_req_arbiter #(
    parameter int N       = 8,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 3
) (
    input logic               CLK,
    input logic               RST,
    alu_req_arbiter_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_RESP} state_t;

    state_t          state;
    logic [ID_W-1:0] win_id;
    logic            lat_mult;
    logic            wait_extra;

    logic            sel_found;
    logic [ID_W-1:0] sel_id;
    logic            grant;
    logic [N-1:0]    sel_opa, sel_opb;
    logic            sel_cin, sel_mode;
    logic [3:0]      sel_cmd;
    logic [1:0]      sel_iv;

`ifdef ALU_FIXED_PRIO_EN
    always_comb begin
        sel_found = |bus.req_valid;
        sel_id    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (bus.req_valid[i]) sel_id = ID_W'(i);
    end
`else
    logic [ID_W-1:0] ptr;
    logic            found_hi;
    logic [ID_W-1:0] hi_id, lo_id;

    // Lowest requester at or above the pointer, else wrap to the lowest overall.
    always_comb begin
        found_hi = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) lo_id = ID_W'(i);
            if (bus.req_valid[i] && (ID_W'(i) >= ptr)) begin
                found_hi = 1'b1;
                hi_id    = ID_W'(i);
            end
        end
        sel_found = |bus.req_valid;
        sel_id    = found_hi ? hi_id : lo_id;
    end
`endif

    // alu_ce doubles as "out of reset", keeping req_ready low during reset.
    assign grant = (state == S_IDLE) && sel_found && bus.alu_ce;

    always_comb begin
        sel_opa  = '0;
        sel_opb  = '0;
        sel_cin  = 1'b0;
        sel_mode = 1'b0;
        sel_cmd  = '0;
        sel_iv   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_ready[i] = grant && (sel_id == ID_W'(i));
            if (sel_id == ID_W'(i)) begin
                sel_opa  = bus.req_opa[i*N +: N];
                sel_opb  = bus.req_opb[i*N +: N];
                sel_cin  = bus.req_cin[i];
                sel_mode = bus.req_mode[i];
                sel_cmd  = bus.req_cmd[i*4 +: 4];
                sel_iv   = bus.req_inp_valid[i*2 +: 2];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state             <= S_IDLE;
            win_id            <= '0;
            lat_mult          <= 1'b0;
            wait_extra        <= 1'b0;
`ifndef ALU_FIXED_PRIO_EN
            ptr               <= '0;
`endif
            bus.rsp_valid     <= 1'b0;
            bus.rsp_id        <= '0;
            bus.rsp_res       <= '0;
            bus.rsp_flags     <= '0;
            bus.alu_opa       <= '0;
            bus.alu_opb       <= '0;
            bus.alu_cin       <= 1'b0;
            bus.alu_mode      <= 1'b0;
            bus.alu_ce        <= 1'b0;
            bus.alu_cmd       <= '0;
            bus.alu_inp_valid <= '0;
        end else begin
            bus.alu_ce <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (grant) begin
                        win_id            <= sel_id;
                        bus.alu_opa       <= sel_opa;
                        bus.alu_opb       <= sel_opb;
                        bus.alu_cin       <= sel_cin;
                        bus.alu_mode      <= sel_mode;
                        bus.alu_cmd       <= sel_cmd;
                        bus.alu_inp_valid <= sel_iv;
                        lat_mult          <= sel_mode && (sel_iv == 2'b11) &&
                                             ((sel_cmd == 4'b1001) || (sel_cmd == 4'b1010));
                        state             <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    bus.alu_inp_valid <= 2'b00;
                    wait_extra        <= lat_mult;
                    state             <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_extra) wait_extra <= 1'b0;
                    else            state      <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    bus.rsp_res   <= bus.alu_res;
                    bus.rsp_flags <= bus.alu_flags;
                    bus.rsp_id    <= win_id;
                    bus.rsp_valid <= 1'b1;
                    state         <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
`ifndef ALU_FIXED_PRIO_EN
                        ptr <= (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
`endif
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: behavioural ALU stand-in, vector table, scoreboard queue,
// hand-written backpressure / mid-operation reset / arbitration-order sequences.
module tb_alu_req_arbiter;
    logic CLK;
    logic RST;
    int   cyc;
    int   total;
    int   bad;

    alu_req_arbiter_if #(.N(8), .NUM_REQ(4), .ID_W(3)) bus();
    alu_req_arbiter #(.N(8), .NUM_REQ(4), .ID_W(3)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---- ALU stand-in: 1-cycle latency, multiply 2-cycle (shows 0 in between) ----
    logic [16:0] m_res_q, m_pend_res;
    logic [6:0]  m_flags_q, m_pend_flags;
    logic        m_pend;
    assign bus.alu_res   = m_res_q;
    assign bus.alu_flags = m_flags_q;

    function automatic logic [23:0] alu_fn(input logic mode, input logic [3:0] cmd,
                                          input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] iv);
        logic [16:0] r;
        logic        err;
        logic        cout;
        r   = '0;
        err = 1'b0;
        if (iv != 2'b11) err = 1'b1;
        else if (mode) begin
            case (cmd)
                4'b0000: r = 17'(a) + 17'(b);
                4'b0001: r = 17'(a) - 17'(b);
                4'b1001: r = (17'(a) + 17'd1) * (17'(b) + 17'd1);
                4'b1010: r = (17'(a) << 1) * 17'(b);
                default: err = 1'b1;
            endcase
        end else begin
            if (cmd == 4'b0000) r = {9'b0, a & b};
            else                err = 1'b1;
        end
        cout = mode && (cmd == 4'b0000) && !err && r[8];
        return {cout, 4'b0000, err, 1'b0, r};
    endfunction

    initial begin
        m_res_q = '0; m_flags_q = '0; m_pend = 1'b0; m_pend_res = '0; m_pend_flags = '0;
    end

    always @(posedge CLK) begin
        logic [23:0] f;
        if (m_pend) begin
            m_res_q   <= m_pend_res;
            m_flags_q <= m_pend_flags;
            m_pend    <= 1'b0;
        end
        if (bus.alu_ce && bus.alu_inp_valid != 2'b00) begin
            f = alu_fn(bus.alu_mode, bus.alu_cmd, bus.alu_opa, bus.alu_opb, bus.alu_inp_valid);
            if (bus.alu_mode && bus.alu_inp_valid == 2'b11 &&
                (bus.alu_cmd == 4'b1001 || bus.alu_cmd == 4'b1010)) begin
                m_res_q      <= '0;
                m_flags_q    <= '0;
                m_pend_res   <= f[16:0];
                m_pend_flags <= f[23:17];
                m_pend       <= 1'b1;
            end else begin
                m_res_q   <= f[16:0];
                m_flags_q <= f[23:17];
            end
        end
    end

    // ---- scoreboard ----
    typedef struct packed {
        logic [2:0]  id;
        logic [16:0] res;
        logic [6:0]  flags;
    } rsp_t;

    rsp_t exp_for [4];
    rsp_t exp_q [$];
    int   grant_log [$];

    always @(posedge CLK) if (!RST) exp_q.delete();

    always @(negedge CLK) begin
        rsp_t e;
        if (RST) begin
            if (|bus.req_valid)
                chk("ready_onehot0", 32'($onehot0(bus.req_ready)), 32'd1);
            for (int i = 0; i < 4; i++)
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    exp_q.push_back(exp_for[i]);
                    grant_log.push_back(i);
                end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
                    chk("rsp_res", 32'(bus.rsp_res), 32'(e.res));
                    chk("rsp_flags", 32'(bus.rsp_flags), 32'(e.flags));
                end
            end
        end
    end

    // ---- stimulus helpers ----
    task automatic set_req(input int id, input logic mode, input logic [3:0] cmd,
                           input logic [7:0] a, input logic [7:0] b, input logic [1:0] iv,
                           input logic [16:0] res, input logic cout, input logic err);
        bus.req_mode[id]            = mode;
        bus.req_cmd[id*4 +: 4]      = cmd;
        bus.req_opa[id*8 +: 8]      = a;
        bus.req_opb[id*8 +: 8]      = b;
        bus.req_cin[id]             = 1'b0;
        bus.req_inp_valid[id*2 +: 2] = iv;
        exp_for[id] = '{id: 3'(id), res: res, flags: {cout, 4'b0000, err, 1'b0}};
    endtask

    task automatic wait_grant(input int id, output int gcyc, output logic ok);
        logic [3:0] rr;
        ok   = 1'b0;
        gcyc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            rr = bus.req_ready;
            if (rr[id]) begin
                ok   = 1'b1;
                gcyc = cyc;
                break;
            end
        end
    endtask

    task automatic wait_rsp(output int rcyc, output logic ok);
        ok   = 1'b0;
        rcyc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (bus.rsp_valid) begin
                ok   = 1'b1;
                rcyc = cyc;
                break;
            end
        end
    endtask

    typedef struct {
        int          id;
        logic        mode;
        logic [3:0]  cmd;
        logic [7:0]  opa, opb;
        logic [1:0]  iv;
        logic [16:0] res;
        logic        cout, err;
        int          lat;
    } vec_t;

    vec_t vecs [7];
    int   exp_order [5];

    initial begin
        int   g, r;
        logic ok, seen;

        vecs[0] = '{0, 1'b1, 4'b0000, 8'h0F, 8'h01, 2'b11, 17'h10,  1'b0, 1'b0, 4};
        vecs[1] = '{2, 1'b1, 4'b1001, 8'h03, 8'h04, 2'b11, 17'd20,  1'b0, 1'b0, 5};
        vecs[2] = '{1, 1'b0, 4'b1100, 8'h81, 8'h09, 2'b11, 17'h0,   1'b0, 1'b1, 4};
        vecs[3] = '{3, 1'b1, 4'b0000, 8'hFF, 8'h01, 2'b11, 17'h100, 1'b1, 1'b0, 4};
        vecs[4] = '{1, 1'b1, 4'b1010, 8'h03, 8'h05, 2'b11, 17'd30,  1'b0, 1'b0, 5};
        vecs[5] = '{0, 1'b1, 4'b0001, 8'h09, 8'h03, 2'b11, 17'd6,   1'b0, 1'b0, 4};
        vecs[6] = '{2, 1'b1, 4'b0000, 8'h05, 8'h05, 2'b01, 17'h0,   1'b0, 1'b1, 4};
`ifdef ALU_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif

        cyc = 0; total = 0; bad = 0;
        RST = 1'b0;
        bus.req_valid = '0; bus.req_opa = '0; bus.req_opb = '0; bus.req_cin = '0;
        bus.req_mode = '0; bus.req_cmd = '0; bus.req_inp_valid = '0; bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) exp_for[i] = '0;

        // reset values
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_res", 32'(bus.rsp_res), 32'd0);
        chk("rst_alu_ce", 32'(bus.alu_ce), 32'd0);
        chk("rst_alu_iv", 32'(bus.alu_inp_valid), 32'd0);
        #1 RST = 1'b1;
        @(negedge CLK);
        chk("ce_after_release", 32'(bus.alu_ce), 32'd1);
        chk("idle_alu_iv", 32'(bus.alu_inp_valid), 32'd0);
        chk("idle_req_ready", 32'(bus.req_ready), 32'd0);

        // table: single requester commands
        bus.rsp_ready = 1'b1;
        for (int v = 0; v < 7; v++) begin
            @(posedge CLK); #1;
            set_req(vecs[v].id, vecs[v].mode, vecs[v].cmd, vecs[v].opa, vecs[v].opb,
                    vecs[v].iv, vecs[v].res, vecs[v].cout, vecs[v].err);
            bus.req_valid[vecs[v].id] = 1'b1;
            wait_grant(vecs[v].id, g, ok);
            chk("grant_seen", 32'(ok), 32'd1);
            @(posedge CLK); #1 bus.req_valid[vecs[v].id] = 1'b0;
            @(negedge CLK);
            chk("issue_alu_iv", 32'(bus.alu_inp_valid), 32'(vecs[v].iv));
            chk("issue_alu_opa", 32'(bus.alu_opa), 32'(vecs[v].opa));
            chk("issue_alu_cmd", 32'(bus.alu_cmd), 32'(vecs[v].cmd));
            @(negedge CLK);
            chk("wait_alu_iv", 32'(bus.alu_inp_valid), 32'd0);
            wait_rsp(r, ok);
            chk("rsp_seen", 32'(ok), 32'd1);
            chk("grant_to_rsp", 32'(r - g), 32'(vecs[v].lat));
        end

        // backpressure: response held 10 cycles while another requester waits
        @(posedge CLK); #1;
        bus.rsp_ready = 1'b0;
        set_req(2, 1'b1, 4'b0000, 8'd5, 8'd6, 2'b11, 17'd11, 1'b0, 1'b0);
        bus.req_valid[2] = 1'b1;
        wait_grant(2, g, ok);
        chk("bp_grant2", 32'(ok), 32'd1);
        @(posedge CLK); #1;
        bus.req_valid[2] = 1'b0;
        set_req(1, 1'b1, 4'b0000, 8'd7, 8'd8, 2'b11, 17'd15, 1'b0, 1'b0);
        bus.req_valid[1] = 1'b1;
        wait_rsp(r, ok);
        chk("bp_rsp_seen", 32'(ok), 32'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_rsp_id", 32'(bus.rsp_id), 32'd2);
            chk("bp_rsp_res", 32'(bus.rsp_res), 32'd11);
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
            chk("bp_alu_iv", 32'(bus.alu_inp_valid), 32'd0);
        end
        @(posedge CLK); #1 bus.rsp_ready = 1'b1;
        wait_grant(1, g, ok);
        chk("bp_grant1", 32'(ok), 32'd1);
        @(posedge CLK); #1 bus.req_valid[1] = 1'b0;
        wait_rsp(r, ok);
        chk("bp_rsp1_seen", 32'(ok), 32'd1);

        // reset during WAIT of a multiply
        @(posedge CLK); #1;
        set_req(3, 1'b1, 4'b1001, 8'd2, 8'd2, 2'b11, 17'd9, 1'b0, 1'b0);
        bus.req_valid[3] = 1'b1;
        wait_grant(3, g, ok);
        chk("mr_grant3", 32'(ok), 32'd1);
        @(posedge CLK); #1 bus.req_valid[3] = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        #1 RST = 1'b0;
        @(posedge CLK); #1 RST = 1'b1;
        @(negedge CLK);
        chk("mr_req_ready", 32'(bus.req_ready), 32'd0);
        chk("mr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mr_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("mr_rsp_res", 32'(bus.rsp_res), 32'd0);
        chk("mr_rsp_flags", 32'(bus.rsp_flags), 32'd0);
        chk("mr_alu_opa", 32'(bus.alu_opa), 32'd0);
        chk("mr_alu_cmd", 32'(bus.alu_cmd), 32'd0);
        chk("mr_alu_mode", 32'(bus.alu_mode), 32'd0);
        chk("mr_alu_iv", 32'(bus.alu_inp_valid), 32'd0);
        chk("mr_alu_ce", 32'(bus.alu_ce), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge CLK);
            if (bus.rsp_valid) seen = 1'b1;
        end
        chk("mr_no_rsp", 32'(seen), 32'd0);

        // all requesters continuously valid: grant order from a freshly reset pointer
        @(posedge CLK); #1;
        for (int i = 0; i < 4; i++)
            set_req(i, 1'b1, 4'b0000, 8'(i), 8'd1, 2'b11, 17'(i + 1), 1'b0, 1'b0);
        grant_log.delete();
        bus.req_valid = 4'hF;
        for (int k = 0; k < 80; k++) begin
            @(negedge CLK);
            if (grant_log.size() >= 5) break;
        end
        @(posedge CLK); #1 bus.req_valid = 4'h0;
        wait_rsp(r, ok);
        chk("rr_last_rsp", 32'(ok), 32'd1);
        chk("rr_grants", 32'(grant_log.size() >= 5), 32'd1);
        for (int i = 0; i < 5; i++)
            if (i < grant_log.size())
                chk("rr_order", 32'(grant_log[i]), 32'(exp_order[i]));
        repeat (4) @(negedge CLK);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
